// File: rtl/ddr_read_scheduler_if.sv
// Client-side request bus and engine-side read-DMA handshake of ddr_read_scheduler.
// master: the scheduler; slave: the clients and the DMA engine.
interface ddr_read_scheduler_if #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned LEN_W  = 27
);
  logic [NUM_CH-1:0]        cli_req;
  logic [NUM_CH*ADDR_W-1:0] cli_addr;
  logic [NUM_CH*LEN_W-1:0]  cli_len;
  logic [NUM_CH-1:0]        cli_ack;
  logic [NUM_CH-1:0]        cli_done;
  logic                     dma_req;
  logic [ADDR_W-1:0]        dma_addr;
  logic [LEN_W-1:0]         dma_len;
  logic                     dma_ack;
  logic                     dma_eop;

  modport master (
    input  cli_req, cli_addr, cli_len, dma_ack, dma_eop,
    output cli_ack, cli_done, dma_req, dma_addr, dma_len
  );

  modport slave (
    output cli_req, cli_addr, cli_len, dma_ack, dma_eop,
    input  cli_ack, cli_done, dma_req, dma_addr, dma_len
  );
endinterface

// File: rtl/ddr_read_scheduler.sv
// Round-robin scheduler sharing one DDR read-DMA slot among NUM_CH clients, splitting requests into MAX_BURST segments.
// Optional watchdog enabled by defining DDR_SCHED_TIMEOUT_EN.
module ddr_read_scheduler #(
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned LEN_W       = 27,
  parameter int unsigned MAX_BURST   = 256,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  ddr_read_scheduler_if.master bus,
  output logic [3:0]           cur_ch,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CH_W = 4;
  localparam int unsigned WD_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t              state, state_nx;
  logic [CH_W-1:0]     rr_ptr, rr_ptr_nx, cur_ch_nx;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_nx, dma_addr_q, dma_addr_nx, sel_addr;
  logic [LEN_W-1:0]    remaining, remaining_nx, dma_len_q, dma_len_nx, sel_len;
  logic [NUM_CH-1:0]   cli_ack_q, cli_ack_nx, cli_done_q, cli_done_nx;
  logic                dma_req_q, dma_req_nx, busy_nx;
  logic                gnt_vld;
  logic [CH_W-1:0]     gnt_ch;
  logic [15:0]         req_pad;
`ifdef DDR_SCHED_TIMEOUT_EN
  logic [WD_W-1:0]     wd_cnt, wd_cnt_nx;
  logic                err_q, err_nx;
`endif

  // First requester at or after ptr; MSB of result flags a valid pick
  function automatic logic [CH_W:0] pick_next(input logic [15:0] req, input logic [CH_W-1:0] ptr);
    logic [CH_W:0] res;
    logic [CH_W:0] idx;
    res = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (req[idx[CH_W-1:0]]) res = {1'b1, idx[CH_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < int'(NUM_CH); i++) v[i] = (ch == CH_W'(i));
    return v;
  endfunction

  function automatic logic [LEN_W-1:0] seg_of(input logic [LEN_W-1:0] rem);
    return (rem > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : rem;
  endfunction

  assign req_pad           = 16'(bus.cli_req);
  assign {gnt_vld, gnt_ch} = pick_next(req_pad, rr_ptr);

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (gnt_ch == CH_W'(i)) begin
        sel_addr = bus.cli_addr[i*ADDR_W +: ADDR_W];
        sel_len  = bus.cli_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Next-state and next-output logic; every output is taken from a register
  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    cur_ch_nx    = cur_ch;
    cur_addr_nx  = cur_addr;
    remaining_nx = remaining;
    cli_ack_nx   = '0;
    cli_done_nx  = '0;
    dma_req_nx   = dma_req_q;
    dma_addr_nx  = dma_addr_q;
    dma_len_nx   = dma_len_q;
`ifdef DDR_SCHED_TIMEOUT_EN
    err_nx       = err_q;
    wd_cnt_nx    = '0;
`endif
    case (state)
      S_IDLE: if (|bus.cli_req) state_nx = S_GRANT;
      S_GRANT: begin
        if (!gnt_vld) begin
          state_nx = S_IDLE;
        end else begin
          cur_ch_nx    = gnt_ch;
          cli_ack_nx   = onehot(gnt_ch);
          rr_ptr_nx    = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(gnt_ch + 1'b1);
          cur_addr_nx  = sel_addr;
          remaining_nx = sel_len;
          if (sel_len == '0) begin
            state_nx = S_FINISH;
          end else begin
            state_nx    = S_ISSUE;
            dma_req_nx  = 1'b1;
            dma_addr_nx = sel_addr;
            dma_len_nx  = seg_of(sel_len);
          end
        end
      end
      S_ISSUE: begin
        if (bus.dma_ack) begin
          dma_req_nx   = 1'b0;
          cur_addr_nx  = cur_addr + ADDR_W'(dma_len_q);
          remaining_nx = remaining - dma_len_q;
          state_nx     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.dma_eop) begin
          if (remaining != '0) begin
            state_nx    = S_ISSUE;
            dma_req_nx  = 1'b1;
            dma_addr_nx = cur_addr;
            dma_len_nx  = seg_of(remaining);
          end else begin
            state_nx    = S_FINISH;
            cli_done_nx = onehot(cur_ch);
          end
        end
      end
      S_FINISH: begin
        state_nx = S_IDLE;
        // Zero-length grants arrive here with done still low: pulse it after the ack
        if (cli_done_q == '0) cli_done_nx = onehot(cur_ch);
      end
      default: state_nx = S_IDLE;
    endcase
`ifdef DDR_SCHED_TIMEOUT_EN
    if (state == S_ISSUE || state == S_WAIT) begin
      if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
        err_nx      = 1'b1;
        dma_req_nx  = 1'b0;
        cli_done_nx = onehot(cur_ch);
        state_nx    = S_IDLE;
      end else if (state == S_WAIT && state_nx == S_ISSUE) begin
        wd_cnt_nx = '0;
      end else begin
        wd_cnt_nx = wd_cnt + 1'b1;
      end
    end
`endif
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      cur_addr   <= '0;
      remaining  <= '0;
      cli_ack_q  <= '0;
      cli_done_q <= '0;
      dma_req_q  <= 1'b0;
      dma_addr_q <= '0;
      dma_len_q  <= '0;
      busy       <= 1'b0;
`ifdef DDR_SCHED_TIMEOUT_EN
      wd_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_ptr_nx;
      cur_ch     <= cur_ch_nx;
      cur_addr   <= cur_addr_nx;
      remaining  <= remaining_nx;
      cli_ack_q  <= cli_ack_nx;
      cli_done_q <= cli_done_nx;
      dma_req_q  <= dma_req_nx;
      dma_addr_q <= dma_addr_nx;
      dma_len_q  <= dma_len_nx;
      busy       <= busy_nx;
`ifdef DDR_SCHED_TIMEOUT_EN
      wd_cnt     <= wd_cnt_nx;
      err_q      <= err_nx;
`endif
    end
  end

  assign bus.cli_ack  = cli_ack_q;
  assign bus.cli_done = cli_done_q;
  assign bus.dma_req  = dma_req_q;
  assign bus.dma_addr = dma_addr_q;
  assign bus.dma_len  = dma_len_q;

`ifdef DDR_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_read_scheduler.sv
// Directed bench for ddr_read_scheduler: single client, splitting, round-robin, zero length, ack stall, reset, watchdog.
module tb_ddr_read_scheduler;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned ADDR_W = 27;
  localparam int unsigned LEN_W  = 27;

  logic clk;
  logic rst;
  logic [3:0] cur_ch;
  logic busy;
  logic err;
  int errors = 0;
  int checks = 0;

  ddr_read_scheduler_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  ddr_read_scheduler #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(256), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .cur_ch(cur_ch), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench stopped");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cli(input int ch, input logic [26:0] a, input logic [26:0] l);
    bus.cli_addr[ch*ADDR_W +: ADDR_W] = a;
    bus.cli_len[ch*LEN_W +: LEN_W]    = l;
  endtask

  task automatic wait_dma_req(input string tag);
    for (int i = 0; i < 20 && !bus.dma_req; i++) tick();
    check(tag, 32'(bus.dma_req), 32'd1);
  endtask

  // Expect the given segment on the engine port, stall ack, then ack and send eop
  task automatic segment(input string tag, input logic [26:0] a, input logic [26:0] l, input int stall);
    check({tag, "_addr"}, 32'(bus.dma_addr), 32'(a));
    check({tag, "_len"}, 32'(bus.dma_len), 32'(l));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_req"}, 32'(bus.dma_req), 32'd1);
      check({tag, "_stall_addr"}, 32'(bus.dma_addr), 32'(a));
      check({tag, "_stall_len"}, 32'(bus.dma_len), 32'(l));
    end
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(bus.dma_req), 32'd0);
    tick();
    bus.dma_eop = 1'b1;
    tick();
    bus.dma_eop = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.cli_req  = '0;
    bus.cli_addr = '0;
    bus.cli_len  = '0;
    bus.dma_ack  = 1'b0;
    bus.dma_eop  = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dma_req", 32'(bus.dma_req), 32'd0);
    check("rst_ack", 32'(bus.cli_ack), 32'd0);
    check("rst_done", 32'(bus.cli_done), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    // Single client ch3, one segment
    set_cli(3, 27'h100, 27'd10);
    bus.cli_req[3] = 1'b1;
    wait_dma_req("t1_req");
    check("t1_ack", 32'(bus.cli_ack), 32'h0008);
    check("t1_cur_ch", 32'(cur_ch), 32'd3);
    check("t1_busy", 32'(busy), 32'd1);
    bus.cli_req[3] = 1'b0;
    segment("t1_seg", 27'h100, 27'd10, 0);
    check("t1_done", 32'(bus.cli_done), 32'h0008);
    tick();
    check("t1_done_pulse", 32'(bus.cli_done), 32'h0);
    check("t1_idle", 32'(busy), 32'd0);

    // ch0 length 600 splits into 256 + 256 + 88
    set_cli(0, 27'h1000, 27'd600);
    bus.cli_req[0] = 1'b1;
    wait_dma_req("t2_req");
    check("t2_ack", 32'(bus.cli_ack), 32'h0001);
    bus.cli_req[0] = 1'b0;
    segment("t2_seg0", 27'h1000, 27'd256, 0);
    check("t2_nodone0", 32'(bus.cli_done), 32'h0);
    check("t2_reissue0", 32'(bus.dma_req), 32'd1);
    segment("t2_seg1", 27'h1100, 27'd256, 0);
    check("t2_nodone1", 32'(bus.cli_done), 32'h0);
    check("t2_reissue1", 32'(bus.dma_req), 32'd1);
    segment("t2_seg2", 27'h1200, 27'd88, 0);
    check("t2_done", 32'(bus.cli_done), 32'h0001);
    tick();
    check("t2_done_once", 32'(bus.cli_done), 32'h0);

    // Fairness from rr_ptr = 0: grants 1, 5, 15, then re-requesting 1
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    set_cli(1, 27'h200, 27'd4);
    set_cli(5, 27'h500, 27'd4);
    set_cli(15, 27'hF00, 27'd4);
    bus.cli_req = 16'h8022;
    wait_dma_req("t3_req1");
    check("t3_ch1", 32'(cur_ch), 32'd1);
    check("t3_ack1", 32'(bus.cli_ack), 32'h0002);
    bus.cli_req[1] = 1'b0;
    segment("t3_seg1", 27'h200, 27'd4, 0);
    check("t3_done1", 32'(bus.cli_done), 32'h0002);
    wait_dma_req("t3_req5");
    check("t3_ch5", 32'(cur_ch), 32'd5);
    check("t3_ack5", 32'(bus.cli_ack), 32'h0020);
    bus.cli_req[5] = 1'b0;
    set_cli(1, 27'h240, 27'd3);
    bus.cli_req[1] = 1'b1;
    segment("t3_seg5", 27'h500, 27'd4, 0);
    check("t3_done5", 32'(bus.cli_done), 32'h0020);
    wait_dma_req("t3_req15");
    check("t3_ch15", 32'(cur_ch), 32'd15);
    check("t3_ack15", 32'(bus.cli_ack), 32'h8000);
    bus.cli_req[15] = 1'b0;
    segment("t3_seg15", 27'hF00, 27'd4, 0);
    check("t3_done15", 32'(bus.cli_done), 32'h8000);
    wait_dma_req("t3_req1b");
    check("t3_ch1b", 32'(cur_ch), 32'd1);
    bus.cli_req[1] = 1'b0;
    segment("t3_seg1b", 27'h240, 27'd3, 0);
    check("t3_done1b", 32'(bus.cli_done), 32'h0002);
    tick();

    // Zero length on ch7: ack then done, engine untouched
    set_cli(7, 27'h700, 27'd0);
    bus.cli_req[7] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_noreq", 32'(bus.dma_req), 32'd0);
      if (bus.cli_ack != '0) break;
    end
    check("t4_ack", 32'(bus.cli_ack), 32'h0080);
    check("t4_cur_ch", 32'(cur_ch), 32'd7);
    check("t4_done_late", 32'(bus.cli_done), 32'h0);
    bus.cli_req[7] = 1'b0;
    tick();
    check("t4_done", 32'(bus.cli_done), 32'h0080);
    check("t4_noreq_end", 32'(bus.dma_req), 32'd0);
    tick();
    check("t4_done_pulse", 32'(bus.cli_done), 32'h0);
    check("t4_idle", 32'(busy), 32'd0);

    // Ack stall with address wrap, then reset in WAIT
    set_cli(2, 27'h7FFFF00, 27'd300);
    bus.cli_req[2] = 1'b1;
    wait_dma_req("t5_req");
    check("t5_cur_ch", 32'(cur_ch), 32'd2);
    bus.cli_req[2] = 1'b0;
    segment("t5_seg0", 27'h7FFFF00, 27'd256, 20);
    wait_dma_req("t5_req_wrap");
    check("t5_wrap_addr", 32'(bus.dma_addr), 32'h0);
    check("t5_wrap_len", 32'(bus.dma_len), 32'd44);
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    check("t5_wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_req", 32'(bus.dma_req), 32'd0);
    check("t5_rst_addr", 32'(bus.dma_addr), 32'h0);
    check("t5_rst_len", 32'(bus.dma_len), 32'h0);
    check("t5_rst_cur_ch", 32'(cur_ch), 32'd0);
    check("t5_rst_done", 32'(bus.cli_done), 32'h0);
    #2;
    rst = 1'b1;
    tick();
    tick();
    check("t5_stay_idle", 32'(busy), 32'd0);

    // Round-robin pointer restarts at 0 after reset: ch2 before ch9
    set_cli(2, 27'h20, 27'd1);
    set_cli(9, 27'h90, 27'd1);
    bus.cli_req = 16'h0204;
    wait_dma_req("t5b_req2");
    check("t5b_ch2", 32'(cur_ch), 32'd2);
    bus.cli_req[2] = 1'b0;
    segment("t5b_seg2", 27'h20, 27'd1, 0);
    check("t5b_done2", 32'(bus.cli_done), 32'h0004);
    wait_dma_req("t5b_req9");
    check("t5b_ch9", 32'(cur_ch), 32'd9);
    bus.cli_req[9] = 1'b0;
    segment("t5b_seg9", 27'h90, 27'd1, 0);
    check("t5b_done9", 32'(bus.cli_done), 32'h0200);
    tick();
    check("t5b_idle", 32'(busy), 32'd0);

`ifdef DDR_SCHED_TIMEOUT_EN
    // Watchdog: eop never arrives, err rises 50 cycles into the segment
    set_cli(4, 27'h40, 27'd5);
    bus.cli_req[4] = 1'b1;
    wait_dma_req("t6_req");
    bus.cli_req[4] = 1'b0;
    bus.dma_ack = 1'b1;
    tick();
    bus.dma_ack = 1'b0;
    repeat (48) tick();
    check("t6_err_early", 32'(err), 32'd0);
    check("t6_busy_early", 32'(busy), 32'd1);
    tick();
    check("t6_err", 32'(err), 32'd1);
    check("t6_done", 32'(bus.cli_done), 32'h0010);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_req", 32'(bus.dma_req), 32'd0);
    tick();
    check("t6_err_sticky", 32'(err), 32'd1);
    check("t6_done_pulse", 32'(bus.cli_done), 32'h0);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
